// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline registers: turns hazard,
// memory-wait and exception inputs into per-register write enables and clears.
//
// state   | meaning
// RUN     | normal issue, hazards decoded every cycle
// MEMWAIT | data access outstanding, PC..EX/MEM frozen, bubble into MEM/WB
// EXCHOLD | exception just taken, exc_req masked for EXC_HOLDOFF cycles
module pipeline_ctrl #(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT     = 255,
  parameter int TO_W        = 8,
  parameter int EXC_HOLDOFF = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             load_use,
  input  logic             branch_taken,
  input  logic             exc_req,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             idex_we,
  output logic             exmem_we,
  output logic             memwb_we,
  output logic             ifid_clr,
  output logic             idex_clr,
  output logic             exmem_clr,
  output logic             memwb_clr,
  output logic             exc_ack,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_count
);

  localparam int HO_W = (EXC_HOLDOFF < 2) ? 1 : $clog2(EXC_HOLDOFF + 1);
  localparam logic [TO_W-1:0] TO_LIM  = TO_W'(TIMEOUT);
  localparam logic [HO_W-1:0] HO_LOAD = HO_W'(EXC_HOLDOFF);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    EXCHOLD = 2'd2
  } state_t;

  state_t            state;
  logic [TO_W-1:0]   wait_cnt;
  logic [TO_W-1:0]   wait_nxt;
  logic [HO_W-1:0]   hold_cnt;
  logic              exc_take;
  logic              mem_stall;

  // Exceptions are only accepted from RUN; MEMWAIT and EXCHOLD both mask them.
  assign exc_take = (state == RUN) && exc_req;
  assign wait_nxt = (wait_cnt == '1) ? wait_cnt : wait_cnt + TO_W'(1);

  always_comb begin
    if (state == MEMWAIT) mem_stall = !dmem_ready;
    else                  mem_stall = !exc_take && dmem_req && !dmem_ready;
  end

  always_comb begin
    pc_we     = 1'b1;
    ifid_we   = 1'b1;
    idex_we   = 1'b1;
    exmem_we  = 1'b1;
    memwb_we  = 1'b1;
    ifid_clr  = 1'b0;
    idex_clr  = 1'b0;
    exmem_clr = 1'b0;
    memwb_clr = 1'b0;
    exc_ack   = 1'b0;
    if (!reset) begin
      pc_we     = 1'b0;
      ifid_we   = 1'b0;
      idex_we   = 1'b0;
      exmem_we  = 1'b0;
      memwb_we  = 1'b0;
      ifid_clr  = 1'b1;
      idex_clr  = 1'b1;
      exmem_clr = 1'b1;
      memwb_clr = 1'b1;
    end else if (exc_take) begin
      ifid_clr  = 1'b1;
      idex_clr  = 1'b1;
      exmem_clr = 1'b1;
      exc_ack   = 1'b1;
    end else if (mem_stall) begin
      pc_we     = 1'b0;
      ifid_we   = 1'b0;
      idex_we   = 1'b0;
      exmem_we  = 1'b0;
      memwb_clr = 1'b1;
    end else if (!imem_ready) begin
      pc_we    = 1'b0;
      ifid_clr = 1'b1;
    end else if (load_use) begin
      // load_use outranks branch_taken: the branch re-resolves next cycle
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      idex_clr = 1'b1;
    end else if (branch_taken) begin
      ifid_clr = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      wait_cnt    <= '0;
      hold_cnt    <= '0;
      mem_err     <= 1'b0;
      stall_count <= '0;
    end else begin
      if (!pc_we && (stall_count != '1))
        stall_count <= stall_count + CNT_W'(1);

      // The cycle that enters MEMWAIT already counts as a wait cycle.
      if (mem_stall) begin
        wait_cnt <= wait_nxt;
        if (wait_nxt >= TO_LIM)
          mem_err <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end

      case (state)
        RUN: begin
          if (exc_take) begin
            state    <= EXCHOLD;
            hold_cnt <= HO_LOAD;
          end else if (mem_stall) begin
            state <= MEMWAIT;
          end
        end
        MEMWAIT: begin
          if (!mem_stall)
            state <= RUN;
        end
        EXCHOLD: begin
          if (mem_stall) begin
            state    <= MEMWAIT;
            hold_cnt <= '0;
          end else if (hold_cnt <= HO_W'(1)) begin
            state    <= RUN;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt - HO_W'(1);
          end
        end
        default: begin
          state    <= RUN;
          hold_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with a small configuration (4-bit stall
// counter, TIMEOUT=4) so saturation and timeout are reachable quickly.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       imem_ready = 1'b1;
  logic       dmem_req = 1'b0;
  logic       dmem_ready = 1'b0;
  logic       load_use = 1'b0;
  logic       branch_taken = 1'b0;
  logic       exc_req = 1'b0;
  logic       pc_we, ifid_we, idex_we, exmem_we, memwb_we;
  logic       ifid_clr, idex_clr, exmem_clr, memwb_clr;
  logic       exc_ack, mem_err;
  logic [3:0] stall_count;
  logic [9:0] ctl;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(
    .CNT_W(4), .TIMEOUT(4), .TO_W(8), .EXC_HOLDOFF(2)
  ) dut (
    .clk(clk), .reset(reset),
    .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .load_use(load_use), .branch_taken(branch_taken), .exc_req(exc_req),
    .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we),
    .exmem_we(exmem_we), .memwb_we(memwb_we),
    .ifid_clr(ifid_clr), .idex_clr(idex_clr),
    .exmem_clr(exmem_clr), .memwb_clr(memwb_clr),
    .exc_ack(exc_ack), .mem_err(mem_err), .stall_count(stall_count)
  );

  // {pc,ifid,idex,exmem,memwb}_we, {ifid,idex,exmem,memwb}_clr, exc_ack
  assign ctl = {pc_we, ifid_we, idex_we, exmem_we, memwb_we,
                ifid_clr, idex_clr, exmem_clr, memwb_clr, exc_ack};

  localparam logic [9:0] C_RST  = 10'b00000_1111_0;
  localparam logic [9:0] C_NORM = 10'b11111_0000_0;
  localparam logic [9:0] C_MEMS = 10'b00001_0001_0;
  localparam logic [9:0] C_IMIS = 10'b01111_1000_0;
  localparam logic [9:0] C_LU   = 10'b00111_0100_0;
  localparam logic [9:0] C_BR   = 10'b11111_1000_0;
  localparam logic [9:0] C_EXC  = 10'b11111_1110_1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset asserted: outputs forced immediately
    #1;
    chk("rst_ctl", 32'(ctl), 32'(C_RST));
    chk("rst_stall", 32'(stall_count), 0);
    chk("rst_memerr", 32'(mem_err), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("idle_ctl", 32'(ctl), 32'(C_NORM));
    chk("idle_stall", 32'(stall_count), 0);
    step();

    // three-cycle data memory wait
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("memwait_%0d", i), 32'(ctl), 32'(C_MEMS));
      step();
    end
    dmem_ready = 1'b1;
    #1;
    chk("memdone_ctl", 32'(ctl), 32'(C_NORM));
    step();
    dmem_req = 1'b0; dmem_ready = 1'b0;
    #1;
    chk("memwait_stall", 32'(stall_count), 3);
    chk("memwait_noerr", 32'(mem_err), 0);

    // load_use beats branch_taken
    load_use = 1'b1; branch_taken = 1'b1;
    #1;
    chk("lu_br_ctl", 32'(ctl), 32'(C_LU));
    step();
    load_use = 1'b0;
    #1;
    chk("br_ctl", 32'(ctl), 32'(C_BR));
    chk("lu_stall", 32'(stall_count), 4);
    step();
    branch_taken = 1'b0; imem_ready = 1'b0;
    #1;
    chk("imiss_ctl", 32'(ctl), 32'(C_IMIS));
    step();
    imem_ready = 1'b1;
    #1;
    chk("imiss_stall", 32'(stall_count), 5);

    // exception held four cycles: ack in cycles 1 and 4
    exc_req = 1'b1;
    #1;
    chk("exc_c1", 32'(ctl), 32'(C_EXC));
    step();
    chk("exc_c2", 32'(ctl), 32'(C_NORM));
    step();
    chk("exc_c3", 32'(ctl), 32'(C_NORM));
    step();
    chk("exc_c4", 32'(ctl), 32'(C_EXC));
    step();
    // memory stall in EXCHOLD abandons the holdoff, exc masked in MEMWAIT
    exc_req = 1'b0; dmem_req = 1'b1; dmem_ready = 1'b0;
    #1;
    chk("hold_mem_ctl", 32'(ctl), 32'(C_MEMS));
    step();
    exc_req = 1'b1;
    #1;
    chk("memwait_exc_masked", 32'(ctl), 32'(C_MEMS));
    step();
    dmem_ready = 1'b1;
    #1;
    chk("memwait_exit_ctl", 32'(ctl), 32'(C_NORM));
    step();
    dmem_req = 1'b0; dmem_ready = 1'b0;
    #1;
    chk("exc_after_mem", 32'(ctl), 32'(C_EXC));
    chk("exc_stall", 32'(stall_count), 7);
    step();
    exc_req = 1'b0;
    step();
    step();

    // memory timeout: mem_err from the fifth wait cycle, sticky afterwards
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      #1;
      chk($sformatf("timeout_err_%0d", k), 32'(mem_err), (k >= 5) ? 1 : 0);
      chk($sformatf("timeout_ctl_%0d", k), 32'(ctl), 32'(C_MEMS));
      step();
    end
    dmem_ready = 1'b1;
    #1;
    chk("timeout_exit_ctl", 32'(ctl), 32'(C_NORM));
    step();
    dmem_req = 1'b0; dmem_ready = 1'b0;
    #1;
    chk("memerr_sticky", 32'(mem_err), 1);
    chk("timeout_stall", 32'(stall_count), 13);

    // stall counter saturation
    imem_ready = 1'b0;
    for (int i = 0; i < 20; i++) step();
    imem_ready = 1'b1;
    #1;
    chk("stall_sat", 32'(stall_count), 15);

    // async reset in MEMWAIT
    dmem_req = 1'b1; dmem_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("midrst_ctl", 32'(ctl), 32'(C_RST));
    chk("midrst_stall", 32'(stall_count), 0);
    chk("midrst_memerr", 32'(mem_err), 0);
    step();
    dmem_req = 1'b0;
    reset = 1'b1;
    #1;
    chk("post_rst_run", 32'(ctl), 32'(C_NORM));
    step();
    chk("post_rst_stall", 32'(stall_count), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
